// File: rtl/cp0_defs.sv
// Shared CP0 constants: register numbers, exception-encoder codes, ExcCode values,
// writable-bit masks and the code-to-ExcCode mapping.
package cp0_defs;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    localparam logic [31:0] ET_INT  = 32'h0000_0001;
    localparam logic [31:0] ET_ADEL = 32'h0000_0004;
    localparam logic [31:0] ET_ADES = 32'h0000_0005;
    localparam logic [31:0] ET_SYS  = 32'h0000_0008;
    localparam logic [31:0] ET_BP   = 32'h0000_0009;
    localparam logic [31:0] ET_RI   = 32'h0000_000A;
    localparam logic [31:0] ET_OV   = 32'h0000_000C;
    localparam logic [31:0] ET_ERET = 32'h0000_000E;

    localparam logic [4:0] EC_INT  = 5'h00;
    localparam logic [4:0] EC_ADEL = 5'h04;
    localparam logic [4:0] EC_ADES = 5'h05;
    localparam logic [4:0] EC_SYS  = 5'h08;
    localparam logic [4:0] EC_BP   = 5'h09;
    localparam logic [4:0] EC_RI   = 5'h0A;
    localparam logic [4:0] EC_OV   = 5'h0C;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // Unrecognised nonzero codes are reported as reserved instruction.
    function automatic logic [4:0] exc_code(input logic [31:0] et);
        case (et)
            ET_INT:  exc_code = EC_INT;
            ET_ADEL: exc_code = EC_ADEL;
            ET_ADES: exc_code = EC_ADES;
            ET_SYS:  exc_code = EC_SYS;
            ET_BP:   exc_code = EC_BP;
            ET_OV:   exc_code = EC_OV;
            default: exc_code = EC_RI;
        endcase
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clk, TI latches one cycle after a match.
// Register writes take effect on the next edge; no backpressure.
module cp0_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick    <= 1'b0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            tick <= ~tick;
            if (count_we)
                count <= wdata;
            else if (tick)
                count <= count + 32'd1;
            if (compare_we)
                compare <= wdata;
            // Rewriting Compare acknowledges the interrupt, even against a fresh match.
            if (compare_we)
                ti <= 1'b0;
            else if (count == compare)
                ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: exception capture, MTC0/MFC0, flush/redirect; updates one cycle after inputs,
// flush_o/newpc_o/data_o combinational, no backpressure. Timer present only with CP0_TIMER_EN.
module cp0_reg
    import cp0_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o,
    output logic        flush_o,
    output logic [31:0] newpc_o
);

    logic        is_exc;
    logic        is_eret;
    logic        mtc0;
    logic [31:0] status_r;
    logic [31:0] epc_r;
    logic [31:0] badvaddr_r;
    logic        bd;
    logic [1:0]  ip_sw;
    logic [5:0]  int_q;
    logic [4:0]  exccode;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    assign is_exc  = (excepttype_i != '0);
    assign is_eret = (excepttype_i == ET_ERET);
    // An MTC0 sharing a cycle with an exception belongs to a flushed instruction.
    assign mtc0    = we_i & ~is_exc;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_we   (mtc0 && (waddr_i == REG_COUNT)),
        .compare_we (mtc0 && (waddr_i == REG_COMPARE)),
        .wdata      (wdata_i),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_r   <= STATUS_BEV;
            epc_r      <= '0;
            badvaddr_r <= '0;
            bd         <= 1'b0;
            ip_sw      <= '0;
            int_q      <= '0;
            exccode    <= '0;
        end else begin
            int_q <= int_i;
            if (is_exc && !is_eret) begin
                if (!status_r[1]) begin
                    epc_r <= is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                    bd    <= is_in_delayslot_i;
                end
                status_r[1] <= 1'b1;
                exccode     <= exc_code(excepttype_i);
                if (excepttype_i == ET_ADEL || excepttype_i == ET_ADES)
                    badvaddr_r <= bad_addr_i;
            end else if (is_eret) begin
                status_r[1] <= 1'b0;
            end else if (mtc0) begin
                case (waddr_i)
                    REG_STATUS:   status_r   <= (wdata_i & STATUS_WMASK) | STATUS_BEV;
                    REG_CAUSE:    ip_sw      <= wdata_i[9:8] & CAUSE_WMASK[9:8];
                    REG_EPC:      epc_r      <= wdata_i;
                    REG_BADVADDR: badvaddr_r <= wdata_i;
                    default:      ;
                endcase
            end
        end
    end

    assign status_o    = status_r;
    assign epc_o       = epc_r;
    assign badvaddr_o  = badvaddr_r;
    assign timer_int_o = ti;
    assign cause_o     = {bd, ti, 14'd0, int_q[5] | ti, int_q[4:0], ip_sw, 1'b0, exccode, 2'b00};
    assign flush_o     = is_exc;
    assign newpc_o     = is_eret ? epc_r : EXC_VECTOR;

    always_comb begin
        data_o = '0;
        case (raddr_i)
            REG_BADVADDR: data_o = badvaddr_r;
            REG_COUNT:    data_o = count;
            REG_COMPARE:  data_o = compare;
            REG_STATUS:   data_o = status_o;
            REG_CAUSE:    data_o = cause_o;
            REG_EPC:      data_o = epc_r;
            REG_PRID:     data_o = PRID_VAL;
            default:      data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg; timer expectations switch on CP0_TIMER_EN.
module tb_cp0_reg;

`ifdef CP0_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [5:0]  int_in;
    logic [31:0] exc;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] data_o, status_o, cause_o, epc_o, badvaddr_o, newpc_o;
    logic        timer_int_o, flush_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cp0_reg dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .we_i              (we),
        .waddr_i           (waddr),
        .wdata_i           (wdata),
        .raddr_i           (raddr),
        .int_i             (int_in),
        .excepttype_i      (exc),
        .pc_i              (pc),
        .is_in_delayslot_i (ds),
        .bad_addr_i        (bad),
        .data_o            (data_o),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .badvaddr_o        (badvaddr_o),
        .timer_int_o       (timer_int_o),
        .flush_o           (flush_o),
        .newpc_o           (newpc_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic mfc0(input string tag, input logic [4:0] a, input logic [31:0] exp);
        raddr = a;
        #1;
        chk(tag, data_o, exp);
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        int_in = '0; exc = '0; pc = '0; ds = 1'b0; bad = '0;

        @(negedge clk);
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_badvaddr", badvaddr_o, 32'h0);
        chk("rst_ti", {31'd0, timer_int_o}, 32'd0);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        mfc0("rst_mfc0_status", 5'd12, 32'h0040_0000);
        mfc0("rst_mfc0_prid", 5'd15, 32'h0000_4220);
        mfc0("rst_mfc0_cause", 5'd13, 32'h0);

        // Timer: Compare=3 on edge 1, Count=0 on edge 2, match seen after edge 8, TI after edge 9.
        @(negedge clk);
        rst_n = 1'b1;
        we = 1'b1; waddr = 5'd11; wdata = 32'd3;
        step();
        waddr = 5'd9; wdata = 32'd0;
        step();
        we = 1'b0;
        repeat (6) step();
        mfc0("count_at_match", 5'd9, TMR ? 32'd3 : 32'd0);
        chk("ti_before", {31'd0, timer_int_o}, 32'd0);
        step();
        chk("ti_set", {31'd0, timer_int_o}, {31'd0, TMR});
        chk("cause_ti", {31'd0, cause_o[30]}, {31'd0, TMR});
        chk("cause_ip7_ti", {31'd0, cause_o[15]}, {31'd0, TMR});
        mfc0("mfc0_compare", 5'd11, TMR ? 32'd3 : 32'd0);
        // Count is still 3 here, so this Compare write collides with a fresh match.
        mtc0(5'd11, 32'd3);
        chk("ti_clear_on_match", {31'd0, timer_int_o}, 32'd0);
        step();
        chk("ti_stays_clear", {31'd0, timer_int_o}, 32'd0);

        we = 1'b1; waddr = 5'd12; wdata = 32'hFFFF_FFFF; raddr = 5'd12;
        #1;
        chk("mfc0_no_bypass", data_o, 32'h0040_0000);
        step();
        we = 1'b0;
        chk("status_mask", data_o, 32'h0040_FF03);
        mtc0(5'd12, 32'h0);
        mtc0(5'd13, 32'hFFFF_FFFF);
        mfc0("cause_mask", 5'd13, 32'h0000_0300);
        mtc0(5'd13, 32'h0);
        int_in = 6'b100001;
        step();
        chk("cause_ip_hw", cause_o, 32'h0000_8400);
        int_in = '0;
        step();
        chk("cause_ip_hw_clr", cause_o, 32'h0);

        // Syscall with a same-cycle MTC0 to EPC that must be discarded.
        exc = 32'h8; pc = 32'hBFC0_0100; ds = 1'b0;
        we = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_BEEF;
        #1;
        chk("sys_flush", {31'd0, flush_o}, 32'd1);
        chk("sys_newpc", newpc_o, 32'hBFC0_0380);
        step();
        exc = '0; we = 1'b0;
        #1;
        chk("sys_epc", epc_o, 32'hBFC0_0100);
        chk("sys_status", status_o, 32'h0040_0002);
        chk("sys_cause", cause_o, 32'h0000_0020);
        chk("idle_flush", {31'd0, flush_o}, 32'd0);
        mtc0(5'd12, 32'h0);

        exc = 32'h4; ds = 1'b1; pc = 32'h8000_0010; bad = 32'h8000_0003;
        step();
        exc = '0; ds = 1'b0;
        chk("adel_epc", epc_o, 32'h8000_000C);
        chk("adel_cause", cause_o, 32'h8000_0010);
        chk("adel_badvaddr", badvaddr_o, 32'h8000_0003);
        chk("adel_status", status_o, 32'h0040_0002);

        exc = 32'hC; pc = 32'h1234_5678; bad = 32'hFFFF_0000;
        step();
        exc = '0;
        chk("nested_epc", epc_o, 32'h8000_000C);
        chk("nested_cause", cause_o, 32'h8000_0030);
        chk("nested_badvaddr", badvaddr_o, 32'h8000_0003);

        exc = 32'h3;
        step();
        exc = '0;
        chk("unknown_as_ri", cause_o, 32'h8000_0028);

        mtc0(5'd14, 32'h8000_0040);
        exc = 32'hE;
        #1;
        chk("eret_newpc", newpc_o, 32'h8000_0040);
        chk("eret_flush", {31'd0, flush_o}, 32'd1);
        step();
        exc = '0;
        chk("eret_status", status_o, 32'h0040_0000);
        chk("eret_epc", epc_o, 32'h8000_0040);
        chk("eret_cause", cause_o, 32'h8000_0028);

        mfc0("unlisted_read", 5'd3, 32'h0);
        mtc0(5'd15, 32'h0);
        mfc0("prid_ro", 5'd15, 32'h0000_4220);

        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_status", status_o, 32'h0040_0000);
        chk("arst_epc", epc_o, 32'h0);
        chk("arst_cause", cause_o, 32'h0);
        chk("arst_badvaddr", badvaddr_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
